// File: rtl/additive_voice_engine.sv
// Additive voice engine: per sample tick, sums up to HARMONICS decaying sine
// partials of one fundamental, with Nyquist cutoff, hard sync and overrun restart.
module additive_voice_engine #(
  parameter int HARMONICS     = 8,
  parameter int SAMPLE_RATE   = 48000,
  parameter int PHASE_BITS    = 16,
  parameter int LUT_ADDR_BITS = 11,
  parameter int LUT_SHIFT     = 5,
  parameter int LUT_LATENCY   = 2,
  parameter int SAMPLE_BITS   = 16,
  parameter int AMP_BITS      = 7,
  parameter int OUT_BITS      = 16,
  parameter int OUT_SHIFT     = 2
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          sample_tick,
  input  logic [PHASE_BITS-1:0]         frequency,
  input  logic [AMP_BITS-1:0]           decay,
  input  logic [7:0]                    harmonic_limit,
  input  logic                          sync,
  output logic [LUT_ADDR_BITS-1:0]      lut_addr,
  input  logic signed [SAMPLE_BITS-1:0] lut_data,
  output logic [OUT_BITS-1:0]           sample_out,
  output logic                          sample_valid,
  output logic                          busy,
  output logic                          overrun,
  output logic [7:0]                    active_harmonics,
  output logic [2:0]                    state_dbg
);

  localparam int ACC_W  = SAMPLE_BITS + $clog2(HARMONICS) + 1;
  localparam int IDX_W  = (HARMONICS > 1) ? $clog2(HARMONICS) : 1;
  localparam int WAIT_W = (LUT_LATENCY > 1) ? $clog2(LUT_LATENCY) : 1;
  localparam int PROD_W = SAMPLE_BITS + AMP_BITS + 1;
  localparam int SAT_W  = ((ACC_W > OUT_BITS) ? ACC_W : OUT_BITS) + 2;

  localparam logic [PHASE_BITS:0]    SR_EXT    = (PHASE_BITS+1)'(SAMPLE_RATE);
  localparam logic [PHASE_BITS:0]    NYQ       = (PHASE_BITS+1)'(SAMPLE_RATE / 2);
  localparam logic [7:0]             HMAX      = 8'(HARMONICS);
  localparam logic [WAIT_W-1:0]      WAIT_LAST = WAIT_W'(LUT_LATENCY - 1);
  localparam logic [AMP_BITS-1:0]    AMP_MAX   = '1;
  localparam logic [OUT_BITS-1:0]    OUT_MID   = {1'b1, {(OUT_BITS-1){1'b0}}};
  localparam logic signed [SAT_W-1:0] SAT_MID  = {{(SAT_W-OUT_BITS){1'b0}}, OUT_MID};
  localparam logic signed [SAT_W-1:0] SAT_TOP  = {{(SAT_W-OUT_BITS){1'b0}}, {OUT_BITS{1'b1}}};

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_PHASE    = 3'd1,
    S_LUT_WAIT = 3'd2,
    S_MAC      = 3'd3,
    S_DONE     = 3'd4
  } state_t;

  // Protocol: sample_tick is a one-cycle request with no ready; a tick while busy
  // pulses overrun and restarts. sample_valid is a one-cycle pulse with sample_out
  // already updated in that cycle; sample_out holds until the next pulse.
  state_t                    state_q, state_d;
  logic [7:0]                n_q, n_d, lim_q, lim_d, active_q, active_d;
  logic [PHASE_BITS-1:0]     freq_q, freq_d;
  logic [AMP_BITS-1:0]       decay_q, decay_d, amp_q, amp_d;
  logic [PHASE_BITS:0]       inc_q, inc_d;
  logic signed [ACC_W-1:0]   acc_q, acc_d;
  logic [WAIT_W-1:0]         wait_q, wait_d;
  logic [LUT_ADDR_BITS-1:0]  lut_addr_q, lut_addr_d;
  logic [OUT_BITS-1:0]       sample_out_q, sample_out_d;
  logic                      sample_valid_q, sample_valid_d;
  logic                      overrun_q, overrun_d;

  logic [PHASE_BITS-1:0]     phase_q [HARMONICS];
  logic                      phase_we, phase_clr;
  logic [IDX_W-1:0]          idx;
  logic [PHASE_BITS:0]       p_sum, p_wrap;
  logic signed [PROD_W-1:0]  prod, term;
  logic signed [SAT_W-1:0]   acc_wide, biased;
  logic [7:0]                lim_eff;

  assign idx     = n_q[IDX_W-1:0];
  assign lim_eff = (harmonic_limit == 8'd0 || harmonic_limit > HMAX) ? HMAX : harmonic_limit;

  always_comb begin
    state_d        = state_q;
    n_d            = n_q;
    lim_d          = lim_q;
    active_d       = active_q;
    freq_d         = freq_q;
    decay_d        = decay_q;
    amp_d          = amp_q;
    inc_d          = inc_q;
    acc_d          = acc_q;
    wait_d         = wait_q;
    lut_addr_d     = lut_addr_q;
    sample_out_d   = sample_out_q;
    sample_valid_d = 1'b0;
    overrun_d      = 1'b0;
    phase_we       = 1'b0;
    phase_clr      = 1'b0;

    // inc never exceeds Nyquist here, so the sum needs at most one subtraction.
    p_sum  = {1'b0, phase_q[idx]} + inc_q;
    p_wrap = (p_sum >= SR_EXT) ? (p_sum - SR_EXT) : p_sum;

    prod = lut_data * $signed({1'b0, amp_q});
    term = prod >>> AMP_BITS;

    acc_wide = SAT_W'(acc_q) >>> OUT_SHIFT;
    biased   = acc_wide + SAT_MID;

    if (sample_tick) begin
      overrun_d = (state_q != S_IDLE);
      freq_d    = frequency;
      decay_d   = decay;
      lim_d     = lim_eff;
      n_d       = 8'd0;
      inc_d     = {1'b0, frequency};
      amp_d     = AMP_MAX;
      acc_d     = '0;
      phase_clr = sync;
      state_d   = S_PHASE;
    end else begin
      case (state_q)
        S_IDLE: ;
        S_PHASE: begin
          if (inc_q > NYQ || n_q == lim_q) begin
            state_d = S_DONE;
          end else begin
            phase_we   = 1'b1;
            lut_addr_d = LUT_ADDR_BITS'(p_wrap >> LUT_SHIFT);
            wait_d     = '0;
            state_d    = S_LUT_WAIT;
          end
        end
        S_LUT_WAIT: begin
          if (wait_q == WAIT_LAST) state_d = S_MAC;
          else                     wait_d  = wait_q + 1'b1;
        end
        S_MAC: begin
          acc_d   = acc_q + ACC_W'(term);
          amp_d   = (amp_q > decay_q) ? (amp_q - decay_q) : '0;
          n_d     = n_q + 8'd1;
          inc_d   = inc_q + {1'b0, freq_q};
          state_d = S_PHASE;
        end
        S_DONE: begin
          if (biased < 0)            sample_out_d = '0;
          else if (biased > SAT_TOP) sample_out_d = '1;
          else                       sample_out_d = biased[OUT_BITS-1:0];
          sample_valid_d = 1'b1;
          active_d       = n_q;
          state_d        = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q        <= S_IDLE;
      n_q            <= '0;
      lim_q          <= '0;
      active_q       <= '0;
      freq_q         <= '0;
      decay_q        <= '0;
      amp_q          <= '0;
      inc_q          <= '0;
      acc_q          <= '0;
      wait_q         <= '0;
      lut_addr_q     <= '0;
      sample_out_q   <= OUT_MID;
      sample_valid_q <= 1'b0;
      overrun_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      n_q            <= n_d;
      lim_q          <= lim_d;
      active_q       <= active_d;
      freq_q         <= freq_d;
      decay_q        <= decay_d;
      amp_q          <= amp_d;
      inc_q          <= inc_d;
      acc_q          <= acc_d;
      wait_q         <= wait_d;
      lut_addr_q     <= lut_addr_d;
      sample_out_q   <= sample_out_d;
      sample_valid_q <= sample_valid_d;
      overrun_q      <= overrun_d;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < HARMONICS; i++) phase_q[i] <= '0;
    end else if (phase_clr) begin
      for (int i = 0; i < HARMONICS; i++) phase_q[i] <= '0;
    end else if (phase_we) begin
      phase_q[idx] <= p_wrap[PHASE_BITS-1:0];
    end
  end

  assign lut_addr         = lut_addr_q;
  assign sample_out       = sample_out_q;
  assign sample_valid     = sample_valid_q;
  assign overrun          = overrun_q;
  assign busy             = (state_q != S_IDLE);
  assign active_harmonics = active_q;
  assign state_dbg        = state_q;

endmodule

// File: doc/additive_voice_engine.md
Name: additive_voice_engine

Overview:
- Parametrised successor to the fixed 7-harmonic additive oscillator datapath.
- Once per sample tick it advances a phase accumulator for each of up to HARMONICS harmonics of one fundamental and reads each harmonic's sine from an external synchronous LUT.
- It scales each sine value by a decaying amplitude, accumulates the scaled values, and emits one offset-binary sample for the DAC serialiser.
- New behaviour over the fixed design: anti-alias (Nyquist) harmonic cutoff, runtime amplitude decay and harmonic limit, hard sync, and overrun detection.

Parameters:
- HARMONICS, 8, maximum harmonics computed per sample (1..255).
- SAMPLE_RATE, 48000, phase modulus; phase range is 0..SAMPLE_RATE-1.
- PHASE_BITS, 16, phase register width; must satisfy 2^PHASE_BITS > SAMPLE_RATE.
- LUT_ADDR_BITS, 11, LUT address width.
- LUT_SHIFT, 5, lut_addr = phase >> LUT_SHIFT.
- LUT_LATENCY, 2, cycles from lut_addr change to valid lut_data.
- SAMPLE_BITS, 16, signed LUT sample width.
- AMP_BITS, 7, amplitude width; full scale AMP_MAX = 2^AMP_BITS-1.
- OUT_BITS, 16, output sample width.
- OUT_SHIFT, 2, arithmetic right shift applied to the accumulator before output.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- sample_tick  in  1  one-cycle pulse that starts the computation of one sample.
- frequency  in  PHASE_BITS  fundamental phase increment (Hz when SAMPLE_RATE=48000); sampled on tick.
- decay  in  AMP_BITS  amplitude decrement applied per harmonic; sampled on tick.
- harmonic_limit  in  8  runtime cap on harmonics; 0 means HARMONICS; sampled on tick.
- sync  in  1  if high on tick, all phases are zeroed before this sample's update.
- lut_addr  out  LUT_ADDR_BITS  sine LUT address.
- lut_data  in  SAMPLE_BITS  signed LUT output.
- sample_out  out  OUT_BITS  offset-binary sample; held between updates.
- sample_valid  out  1  one-cycle pulse when sample_out updates.
- busy  out  1  high whenever state is not IDLE.
- overrun  out  1  one-cycle pulse when a tick arrives while busy.
- active_harmonics  out  8  harmonic count used for the last completed sample.

Behaviour:
- Reset values: lut_addr 0, sample_out 2^(OUT_BITS-1), sample_valid 0, busy 0, overrun 0, active_harmonics 0. All phase registers, the accumulator and the state are cleared.
- Phase RAM: HARMONICS x PHASE_BITS registers, indexed by harmonic number (0-based). Harmonic n uses increment inc_n = (n+1)*frequency, built by running addition with one extra carry bit.
- FSM states: IDLE, PHASE, LUT_WAIT, MAC, DONE.
- IDLE -> PHASE on sample_tick:
  - latch frequency, decay and the effective limit L = min(harmonic_limit or HARMONICS, HARMONICS);
  - n = 0, inc = frequency, amp = AMP_MAX, acc = 0;
  - if sync is high, zero all phases.
- PHASE (1 cycle):
  - If inc > SAMPLE_RATE/2 or n == L, go to DONE. This is the Nyquist cutoff; all higher harmonics are also skipped.
  - Otherwise p = phase[n] + inc; if p >= SAMPLE_RATE then p -= SAMPLE_RATE. Write p back to phase[n], set lut_addr = p >> LUT_SHIFT, and go to LUT_WAIT.
- LUT_WAIT: hold for LUT_LATENCY cycles, then go to MAC.
- MAC (1 cycle):
  - acc += (lut_data * amp) >>> AMP_BITS, as a signed-by-unsigned product with sign preserved;
  - acc width is SAMPLE_BITS + clog2(HARMONICS) + 1, so it never wraps;
  - amp = max(amp - decay, 0); n += 1; inc += frequency; go to PHASE.
  - Harmonics whose amp is 0 still advance their phase.
- DONE (1 cycle):
  - s = (acc >>> OUT_SHIFT) + 2^(OUT_BITS-1), saturated to 0..2^OUT_BITS-1;
  - sample_out = s; sample_valid = 1 for this cycle; active_harmonics = n; go to IDLE.
- Latency: with K = harmonics computed, sample_valid rises exactly K*(LUT_LATENCY+2)+2 cycles after the clock edge that samples the tick.
- Overrun: a tick while busy pulses overrun, abandons the current sample, and restarts from the IDLE->PHASE actions using the new inputs.
  - Phases already written for the abandoned sample keep their new values.
  - sample_out is not updated for the abandoned sample.
- frequency == 0: every harmonic passes the Nyquist test and phases stay fixed. K = L.
- Reset mid-computation aborts immediately; no sample_valid pulse is produced.

Test Plan:
- Settings HARMONICS=8, LUT_LATENCY=2, frequency=1000, decay=20, limit=0; tick from reset -> lut_addr sequence 31,62,93,125,156,187,218,250; sample_valid 34 cycles after tick; active_harmonics=8.
- frequency=7000, limit=0 -> only harmonics 1-3 computed (28000>24000); active_harmonics=3; sample_valid 14 cycles after tick.
- Constant lut_data=+16384, decay=0, limit=1 -> acc = 16384*127>>>7 = 16256; sample_out = 4064+32768 = 36832.
- Phase wrap: frequency=1000, tick 48 times -> harmonic-1 phase returns to 0; harmonic-2 phase after tick 25 is 2000.
- Second tick 5 cycles after the first -> overrun pulses exactly once; exactly one sample_valid, at 34 cycles after the second tick.
- sync=1 on a tick after arbitrary history -> the harmonic-1 lut_addr equals frequency>>5 (31 for frequency=1000); reset asserted during LUT_WAIT -> sample_out=32768, no sample_valid, busy=0.
